dmux_stream: RTL and testbench



---
 rtl/dmux_stream.sv | 78 +++++++
 tb/tb_dmux_stream.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmux_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmux_stream                                                  |
// | Description : Registered valid/ready demultiplexer, one input stream to    |
// |               2^NB_SEL output channels with a one-word register per channel|
// |               Optional broadcast port: define DMUX_STREAM_BCAST_EN.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmux_stream #(
    parameter int BUS_WIDTH = 8,
    parameter int NB_SEL    = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [BUS_WIDTH-1:0]                in_data,
    input  logic [NB_SEL-1:0]                   in_sel,
    input  logic                                in_valid,
    output logic                                in_ready,
`ifdef DMUX_STREAM_BCAST_EN
    input  logic                                in_bcast,
`endif
    output logic [(2**NB_SEL)*BUS_WIDTH-1:0]    out_data,
    output logic [(2**NB_SEL)-1:0]              out_valid,
    input  logic [(2**NB_SEL)-1:0]              out_ready,
    output logic                                busy
);

    localparam int c_NCH = 2**NB_SEL;

    logic [c_NCH-1:0]     r_valid;
    logic [BUS_WIDTH-1:0] r_buf [c_NCH];
    logic [c_NCH-1:0]     w_can_take;
    logic [c_NCH-1:0]     w_load;
    logic                 w_ready;
    logic                 w_accept;

    assign w_can_take = ~r_valid | out_ready;

`ifdef DMUX_STREAM_BCAST_EN
    // Broadcast is all-or-nothing: every channel must be able to take the word.
    assign w_ready = in_bcast ? (&w_can_take) : w_can_take[in_sel];
`else
    assign w_ready = w_can_take[in_sel];
`endif

    assign in_ready = rst_n & w_ready;
    assign w_accept = in_valid & in_ready;

    generate
        for (genvar k = 0; k < c_NCH; k++) begin : g_ch
`ifdef DMUX_STREAM_BCAST_EN
            assign w_load[k] = w_accept & (in_bcast | (in_sel == NB_SEL'(k)));
`else
            assign w_load[k] = w_accept & (in_sel == NB_SEL'(k));
`endif

            // A load takes priority over a drain so a ready channel refills in place.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[k] <= 1'b0;
                    r_buf[k]   <= '0;
                end else if (w_load[k]) begin
                    r_valid[k] <= 1'b1;
                    r_buf[k]   <= in_data;
                end else if (r_valid[k] && out_ready[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end

            assign out_data[k*BUS_WIDTH +: BUS_WIDTH] = r_buf[k];
        end
    endgenerate

    assign out_valid = r_valid;
    assign busy      = |r_valid;

endmodule
`default_nettype wire

// File: tb/tb_dmux_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dmux_stream                                               |
// | Description : Directed and scoreboarded checks for dmux_stream.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dmux_stream;

    localparam int BUS_WIDTH = 8;
    localparam int NB_SEL    = 2;
    localparam int c_NCH     = 4;

    logic                         clk;
    logic                         rst_n;
    logic [BUS_WIDTH-1:0]         in_data;
    logic [NB_SEL-1:0]            in_sel;
    logic                         in_valid;
    logic                         in_ready;
    logic                         in_bcast;
    logic [c_NCH*BUS_WIDTH-1:0]   out_data;
    logic [c_NCH-1:0]             out_valid;
    logic [c_NCH-1:0]             out_ready;
    logic                         busy;

    int n_cmp = 0;
    int n_err = 0;

    dmux_stream #(.BUS_WIDTH(BUS_WIDTH), .NB_SEL(NB_SEL)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
`ifdef DMUX_STREAM_BCAST_EN
        .in_bcast  (in_bcast),
`endif
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [BUS_WIDTH-1:0] ch_data(input int k);
        return out_data[k*BUS_WIDTH +: BUS_WIDTH];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [BUS_WIDTH-1:0] uw [4];
    logic [BUS_WIDTH-1:0] q [c_NCH][$];

    initial begin
        logic [c_NCH-1:0]     exp_valid;
        logic                 exp_ready;
        logic [BUS_WIDTH-1:0] front;
        int                   sent;
        int                   cyc;

        uw[0] = 8'h11; uw[1] = 8'h22; uw[2] = 8'h33; uw[3] = 8'h44;
        rst_n = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0;
        in_bcast = 1'b0; out_ready = '0;

        // Power-on reset
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int s = 0; s < c_NCH; s++) begin
            in_sel = NB_SEL'(s);
            #1;
            chk("post_rst_ready", in_ready, 1);
        end

        // Unicast, one word per channel, one-cycle valid pulses
        out_ready = 4'b1111;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel  = NB_SEL'(i);
            in_data = uw[i];
            #1;
            chk("uni_ready", in_ready, 1);
            step();
            chk("uni_valid", out_valid, 64'(4'b0001 << i));
            chk("uni_data", ch_data(i), uw[i]);
        end
        in_valid = 1'b0;
        step();
        chk("uni_pulse_end", out_valid, 0);
        chk("uni_busy_end", busy, 0);

        // Back-pressure isolation on channel 1
        out_ready = 4'b1101;
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h66;
        step();
        chk("bp_fill", out_valid, 4'b0010);
        in_data = 8'h77;
        #1;
        chk("bp_stall_ready", in_ready, 0);
        step();
        chk("bp_hold_data", ch_data(1), 8'h66);
        in_sel = 2'd3; in_data = 8'h88;
        #1;
        chk("bp_other_ready", in_ready, 1);
        step();
        chk("bp_other_valid", out_valid, 4'b1010);
        chk("bp_other_data", ch_data(3), 8'h88);
        in_sel = 2'd1; in_data = 8'h77; out_ready = 4'b1111;
        #1;
        chk("bp_release_ready", in_ready, 1);
        step();
        chk("bp_refill_valid", out_valid, 4'b0010);
        chk("bp_refill_data", ch_data(1), 8'h77);
        in_valid = 1'b0;
        step();
        chk("bp_empty", out_valid, 0);

        // Same-cycle drain and refill on channel 0
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h99;
        step();
        in_data = 8'h5A;
        #1;
        chk("dr_ready", in_ready, 1);
        chk("dr_old_data", ch_data(0), 8'h99);
        step();
        chk("dr_valid", out_valid[0], 1);
        chk("dr_new_data", ch_data(0), 8'h5A);
        in_valid = 1'b0;
        step();

        // Asynchronous reset with channel 2 holding a word
        out_ready = 4'b1011;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
        step();
        chk("mr_hold", ch_data(2), 8'hA5);
        in_sel = 2'd0; in_data = 8'hFF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", out_valid, 0);
        chk("mr_data", out_data, 0);
        chk("mr_busy", busy, 0);
        chk("mr_ready", in_ready, 0);
        in_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b1;
        step();
        chk("mr_after_valid", out_valid, 0);
        in_sel = 2'd2;
        #1;
        chk("mr_after_ready", in_ready, 1);

`ifdef DMUX_STREAM_BCAST_EN
        // Broadcast blocked by stalled channel 2, then delivered to all
        out_ready = 4'b1011;
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h21;
        step();
        in_bcast = 1'b1; in_sel = 2'd0; in_data = 8'hC3;
        #1;
        chk("bc_blocked_ready", in_ready, 0);
        step();
        chk("bc_no_load_valid", out_valid, 4'b0100);
        chk("bc_no_load_data0", ch_data(0), 8'h00);
        out_ready = 4'b1111;
        #1;
        chk("bc_ready", in_ready, 1);
        step();
        chk("bc_valid", out_valid, 4'b1111);
        for (int k = 0; k < c_NCH; k++)
            chk("bc_data", ch_data(k), 8'hC3);
        in_bcast = 1'b0; in_valid = 1'b0;
        step();
        chk("bc_empty", out_valid, 0);
`endif

        // Random traffic against a per-channel queue model
        sent = 0;
        cyc  = 0;
        in_valid = 1'b0;
        out_ready = '0;
        while (sent < 1000 && cyc < 20000) begin
            in_valid  = $urandom_range(0, 1) == 1;
            in_sel    = NB_SEL'($urandom_range(0, c_NCH-1));
            in_data   = BUS_WIDTH'($urandom);
            out_ready = c_NCH'($urandom);
            #1;
            for (int k = 0; k < c_NCH; k++)
                exp_valid[k] = (q[k].size() != 0);
            exp_ready = !exp_valid[in_sel] || out_ready[in_sel];
            chk("rnd_valid", out_valid, exp_valid);
            chk("rnd_busy", busy, |exp_valid);
            chk("rnd_ready", in_ready, exp_ready);
            for (int k = 0; k < c_NCH; k++) begin
                if (exp_valid[k] && out_ready[k]) begin
                    front = q[k].pop_front();
                    chk("rnd_data", ch_data(k), front);
                end
            end
            if (in_valid && exp_ready) begin
                q[in_sel].push_back(in_data);
                sent++;
            end
            step();
            cyc++;
        end
        if (sent < 1000)
            chk("rnd_budget", sent, 1000);

        in_valid  = 1'b0;
        out_ready = 4'b1111;
        #1;
        for (int k = 0; k < c_NCH; k++) begin
            if (q[k].size() != 0) begin
                front = q[k].pop_front();
                chk("flush_data", ch_data(k), front);
            end
        end
        step();
        chk("flush_valid", out_valid, 0);
        chk("flush_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
